stream_channel_arbiter: RTL and testbench

STREAM_CHANNEL_ARBITER -- requirements
Module: stream_channel_arbiter

---
 rtl/stream_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/stream_channel_arbiter.sv | 142 ++++++++++++++
 tb/tb_stream_channel_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and tag-beat layout for the stream channel arbiter.
// Holds the FSM state encoding, the tag magic byte and the tag field widths.
package stream_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TAG  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam logic [7:0] TAG_MAGIC = 8'hA5;
   localparam int TAG_CH_W  = 8;
   localparam int TAG_SEQ_W = 16;
   localparam int TAG_W     = 8 + TAG_CH_W + TAG_SEQ_W;
   localparam int CNT_W     = 16;

   function automatic logic [TAG_W-1:0] build_tag(input logic [TAG_CH_W-1:0]  ch,
                                                  input logic [TAG_SEQ_W-1:0] seq);
      return {TAG_MAGIC, ch, seq};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search: scans from last_i+1 upward, wrapping at N-1,
// and returns the first requesting index. Purely combinational.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int GW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [GW-1:0] last_i,
   output logic [GW-1:0] grant_o,
   output logic          any_o
);

   logic [GW-1:0] cand;
   logic          found;

   // NOTE: blocking assignments here are intentional; cand is a running
   // value re-evaluated on every loop pass, not a register.
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      cand    = last_i;
      for (int i = 0; i < N; i++) begin
         cand = (cand == GW'(N - 1)) ? '0 : cand + 1'b1;
         if (!found && req_i[cand]) begin
            grant_o = cand;
            found   = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/stream_channel_arbiter.sv
// Merges NUM_CH packet streams onto one output, packet-atomic round-robin,
// cutting packets at MAX_PKT_WORDS. Optional tag beat per packet: CHANNEL_TAG_EN.
module stream_channel_arbiter
   import stream_arb_pkg::*;
#(
   parameter  int NUM_CH        = 4,
   parameter  int DATA_W        = 32,
   parameter  int MAX_PKT_WORDS = 375,
   localparam int GW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH*DATA_W-1:0] s_data,
   input  logic [NUM_CH-1:0]        s_valid,
   input  logic [NUM_CH-1:0]        s_last,
   output logic [NUM_CH-1:0]        s_ready,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_valid,
   output logic                     m_last,
   input  logic                     m_ready,
   output logic [GW-1:0]            grant,
   output logic                     busy,
   output logic                     trunc
);

   localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_PKT_WORDS - 1);

   state_e           state_q, state_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [GW-1:0]    last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             trunc_q, trunc_d;
   logic             force_last;
   logic [GW-1:0]    rr_grant;
   logic             any_req;
`ifdef CHANNEL_TAG_EN
   logic [TAG_SEQ_W-1:0] seq_q [NUM_CH];
   logic [TAG_SEQ_W-1:0] seq_d [NUM_CH];
`endif

   rr_arbiter #(
      .N  (NUM_CH),
      .GW (GW)
   ) u_rr (
      .req_i   (s_valid),
      .last_i  (last_grant_q),
      .grant_o (rr_grant),
      .any_o   (any_req)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      trunc_d      = 1'b0;
      force_last   = 1'b0;
      s_ready      = '0;
      m_valid      = 1'b0;
      m_last       = 1'b0;
      m_data       = '0;
`ifdef CHANNEL_TAG_EN
      seq_d        = seq_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d = rr_grant;
               cnt_d   = '0;
`ifdef CHANNEL_TAG_EN
               state_d = ST_TAG;
`else
               state_d = ST_DATA;
`endif
            end
         end
`ifdef CHANNEL_TAG_EN
         ST_TAG: begin
            m_valid             = 1'b1;
            m_data[TAG_W-1:0]   = build_tag(TAG_CH_W'(grant_q), seq_q[grant_q]);
            if (m_ready) begin
               seq_d[grant_q] = seq_q[grant_q] + 1'b1;
               cnt_d          = '0;
               state_d        = ST_DATA;
            end
         end
`endif
         ST_DATA: begin
            force_last       = (cnt_q == MAX_M1);
            m_data           = s_data[grant_q*DATA_W +: DATA_W];
            m_valid          = s_valid[grant_q];
            m_last           = s_last[grant_q] | force_last;
            s_ready[grant_q] = m_ready;
            if (m_valid && m_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (m_last) begin
                  state_d      = ST_IDLE;
                  last_grant_d = grant_q;
                  trunc_d      = force_last & ~s_last[grant_q];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_CH - 1);
         cnt_q        <= '0;
         trunc_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         trunc_q      <= trunc_d;
      end
   end

`ifdef CHANNEL_TAG_EN
   // NOTE: unlike a data buffer, these sequence numbers are visible protocol
   // state, so the small array is reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) seq_q[c] <= '0;
      end else begin
         seq_q <= seq_d;
      end
   end
`endif

   assign grant = grant_q;
   assign busy  = (state_q != ST_IDLE);
   assign trunc = trunc_q;

endmodule

// File: tb/tb_stream_channel_arbiter.sv
// Directed scoreboard bench for stream_channel_arbiter (NUM_CH=4, DATA_W=32,
// MAX_PKT_WORDS=4); expects tag beats when CHANNEL_TAG_EN is defined.
module tb_stream_channel_arbiter;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 32;
   localparam int MAXW   = 4;
   localparam int GW     = 2;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } src_beat_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          ch;
      logic        trunc;
      logic        is_tag;
   } exp_beat_t;

   logic                     clk;
   logic                     reset;
   logic [NUM_CH*DATA_W-1:0] s_data;
   logic [NUM_CH-1:0]        s_valid;
   logic [NUM_CH-1:0]        s_last;
   logic [NUM_CH-1:0]        s_ready;
   logic [DATA_W-1:0]        m_data;
   logic                     m_valid;
   logic                     m_last;
   logic                     m_ready;
   logic [GW-1:0]            grant;
   logic                     busy;
   logic                     trunc;

   src_beat_t   src_q [NUM_CH][$];
   exp_beat_t   exp_q [$];
   logic        mr_pat [$];
   logic [15:0] exp_seq [NUM_CH];
   logic        exp_trunc;
   logic        chk_mirror;
   int          n_beats;
   int          vecs;
   int          miscompares;

   stream_channel_arbiter #(
      .NUM_CH        (NUM_CH),
      .DATA_W        (DATA_W),
      .MAX_PKT_WORDS (MAXW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_ready (s_ready),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_last  (m_last),
      .m_ready (m_ready),
      .grant   (grant),
      .busy    (busy),
      .trunc   (trunc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit src_pending();
      for (int c = 0; c < NUM_CH; c++)
         if (src_q[c].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive();
      for (int c = 0; c < NUM_CH; c++) begin
         if (src_q[c].size() != 0) begin
            s_valid[c]                  = 1'b1;
            s_data[c*DATA_W +: DATA_W]  = src_q[c][0].data;
            s_last[c]                   = src_q[c][0].last;
         end else begin
            s_valid[c]                  = 1'b0;
            s_data[c*DATA_W +: DATA_W]  = '0;
            s_last[c]                   = 1'b0;
         end
      end
      m_ready = (mr_pat.size() != 0) ? mr_pat.pop_front() : 1'b1;
   endtask

   // Source beats plus the expected output: a tag per output packet (if
   // enabled) and a forced last every MAXW data beats.
   task automatic load_pkt(input int ch, input int n, input logic [31:0] base,
                           input logic [31:0] step);
      src_beat_t s;
      exp_beat_t e;
      for (int i = 0; i < n; i++) begin
         s.data = base + 32'(i) * step;
         s.last = (i == n - 1);
         src_q[ch].push_back(s);
`ifdef CHANNEL_TAG_EN
         if (i % MAXW == 0) begin
            e.data   = {8'hA5, 8'(ch), exp_seq[ch]};
            e.last   = 1'b0;
            e.ch     = ch;
            e.trunc  = 1'b0;
            e.is_tag = 1'b1;
            exp_q.push_back(e);
            exp_seq[ch] = exp_seq[ch] + 16'd1;
         end
`endif
         e.data   = s.data;
         e.last   = s.last || (i % MAXW == MAXW - 1);
         e.trunc  = (i % MAXW == MAXW - 1) && !s.last;
         e.ch     = ch;
         e.is_tag = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic cycle();
      logic [NUM_CH-1:0] hs;
      exp_beat_t         e;
      @(negedge clk);
      hs = s_valid & s_ready;
      check("trunc_pulse", trunc, exp_trunc);
      exp_trunc = 1'b0;
      if (chk_mirror && busy)
         check("s_ready0_mirror", s_ready[0],
               (exp_q.size() != 0 && !exp_q[0].is_tag) ? m_ready : 1'b0);
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_beat", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e.data);
            check("m_last", m_last, e.last);
            check("grant", grant, e.ch);
            exp_trunc = e.trunc;
            n_beats++;
         end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++)
         if (hs[c]) void'(src_q[c].pop_front());
      drive();
   endtask

   task automatic drain(input string tag, input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || src_pending()) && k < budget) begin
         cycle();
         k++;
      end
      check({tag, "_left_over"}, exp_q.size(), 0);
   endtask

   task automatic flush_model();
      for (int c = 0; c < NUM_CH; c++) begin
         src_q[c].delete();
         exp_seq[c] = '0;
      end
      exp_q.delete();
      mr_pat.delete();
      exp_trunc = 1'b0;
   endtask

   initial begin
      int start;
      int k;
      clk         = 1'b0;
      reset       = 1'b1;
      s_data      = '0;
      s_valid     = '0;
      s_last      = '0;
      m_ready     = 1'b1;
      chk_mirror  = 1'b0;
      n_beats     = 0;
      vecs        = 0;
      miscompares = 0;
      flush_model();

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_last", m_last, 1'b0);
      check("rst_m_data", m_data, 32'h0);
      check("rst_s_ready", s_ready, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_trunc", trunc, 1'b0);
      check("rst_grant", grant, 2'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      drive();

      // Ch0 three-beat packet, with first-beat latency
      load_pkt(0, 3, 32'h11, 32'h11);
      drive();
      check("idle_busy", busy, 1'b0);
      check("idle_m_valid", m_valid, 1'b0);
      cycle();
      check("lat_busy", busy, 1'b1);
      check("lat_m_valid", m_valid, 1'b1);
      check("lat_grant", grant, 2'd0);
      drain("ch0_pkt", 20);
      check("ch0_busy_after", busy, 1'b0);

      // Ch1 alone sets last_grant=1, then ch1/ch2 together: ch2 first
      load_pkt(1, 2, 32'h100, 32'h1);
      drive();
      drain("ch1_pkt", 20);
      load_pkt(2, 2, 32'h200, 32'h1);
      load_pkt(1, 3, 32'h110, 32'h1);
      drive();
      drain("rr_ch2_ch1", 40);

      // Ch3 six beats cut at four: truncated packet then a two-beat packet
      load_pkt(3, 6, 32'h300, 32'h1);
      drive();
      drain("trunc_pkt", 40);
      cycle();

      // Downstream back-pressure toggling during a ch0 packet
      load_pkt(0, 3, 32'hC1, 32'h1);
      for (int i = 0; i < 8; i++) mr_pat.push_back(i[0] == 1'b0);
      drive();
      chk_mirror = 1'b1;
      drain("stall_pkt", 40);
      chk_mirror = 1'b0;
      mr_pat.delete();

      // All four channels at once after last_grant=0: order 1,2,3,0
      load_pkt(1, 1, 32'hA1, 32'h0);
      load_pkt(2, 2, 32'hA2, 32'h1);
      load_pkt(3, 1, 32'hA3, 32'h0);
      load_pkt(0, 2, 32'hA0, 32'h1);
      drive();
      drain("rr_wrap", 60);

      // Reset in the middle of a five-beat ch0 packet
      load_pkt(0, 5, 32'h50, 32'h1);
      drive();
      start = n_beats;
      k     = 0;
      while (n_beats == start && k < 20) begin
         cycle();
         k++;
      end
      check("pre_reset_beats", n_beats - start, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_m_valid", m_valid, 1'b0);
      check("mid_rst_s_ready", s_ready, 4'h0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_m_data", m_data, 32'h0);
      flush_model();
      drive();
      @(posedge clk);
      #1;
      check("post_rst_m_valid", m_valid, 1'b0);
      check("post_rst_grant", grant, 2'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      load_pkt(0, 3, 32'h70, 32'h1);
      drive();
      drain("after_reset", 20);
      check("after_reset_busy", busy, 1'b0);

      // Two ch2 packets back to back (tag sequence 0 then 1 when tags enabled)
      load_pkt(2, 2, 32'hE0, 32'h1);
      load_pkt(2, 3, 32'hF0, 32'h1);
      drive();
      drain("ch2_two_pkts", 40);
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
